// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-bin power |X|^2 and per-frame peak search on the FFT output stream.
// Optional macro FFT_PEAK_SKIP_DC_EN excludes bin 0 (DC) from the peak search.
module fft_peak_detect #(
   parameter int DW     = 16,
   parameter int N_LOG2 = 8,
   parameter int PW     = 2*DW+1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic              sop_in,
   input  logic [DW-1:0]     re_in,
   input  logic [DW-1:0]     im_in,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [N_LOG2-1:0] res_bin,
   output logic [PW-1:0]     res_pow,
   output logic              short_frame,
   output logic              overrun
);

`ifdef FFT_PEAK_SKIP_DC_EN
   localparam logic SKIP_DC = 1'b1;
`else
   localparam logic SKIP_DC = 1'b0;
`endif
   localparam logic [N_LOG2-1:0] LAST_BIN = '1;
   localparam logic [N_LOG2-1:0] INIT_BIN = N_LOG2'(SKIP_DC);

   typedef enum logic {IDLE, ACC} state_t;

   state_t              state;
   logic [N_LOG2-1:0]   cnt;
   logic                accept;
   logic [N_LOG2-1:0]   bin_c;
   logic signed [2*DW-1:0] re_x, im_x;

   logic                p1_vld, p1_last;
   logic [N_LOG2-1:0]   p1_bin;
   logic [2*DW-1:0]     p1_rr, p1_ii;

   logic                p2_vld, p2_last;
   logic [N_LOG2-1:0]   p2_bin;
   logic [PW-1:0]       p2_pow;

   logic [PW-1:0]       max_pow;
   logic [N_LOG2-1:0]   max_bin;
   logic                done;
   logic                take;

   // An sop beat always restarts at bin 0, in IDLE or mid-frame.
   always_comb begin
      accept = valid_in && (sop_in || state == ACC);
      bin_c  = sop_in ? '0 : cnt;
      re_x   = {{DW{re_in[DW-1]}}, re_in};
      im_x   = {{DW{im_in[DW-1]}}, im_in};
      take   = p2_vld && (p2_bin != '0 || !SKIP_DC) &&
               (p2_bin == INIT_BIN || p2_pow > max_pow);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         short_frame <= 1'b0;
      end else begin
         short_frame <= valid_in && sop_in && (state == ACC);
         if (accept) begin
            if (bin_c == LAST_BIN) begin
               state <= IDLE;
               cnt   <= '0;
            end else begin
               state <= ACC;
               cnt   <= bin_c + N_LOG2'(1);
            end
         end
      end
   end

   // Squares are non-negative, so the low 2*DW bits hold them exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_vld  <= 1'b0;
         p1_last <= 1'b0;
         p1_bin  <= '0;
         p1_rr   <= '0;
         p1_ii   <= '0;
         p2_vld  <= 1'b0;
         p2_last <= 1'b0;
         p2_bin  <= '0;
         p2_pow  <= '0;
      end else begin
         p1_vld  <= accept;
         p1_last <= accept && (bin_c == LAST_BIN);
         p1_bin  <= bin_c;
         p1_rr   <= re_x * re_x;
         p1_ii   <= im_x * im_x;
         p2_vld  <= p1_vld;
         p2_last <= p1_vld && p1_last;
         p2_bin  <= p1_bin;
         p2_pow  <= PW'(p1_rr) + PW'(p1_ii);
      end
   end

   // The init bin overwrites whatever an earlier (possibly aborted) frame left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_pow <= '0;
         max_bin <= '0;
         done    <= 1'b0;
      end else begin
         done <= p2_vld && p2_last;
         if (take) begin
            max_pow <= p2_pow;
            max_bin <= p2_bin;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_bin   <= '0;
         res_pow   <= '0;
         overrun   <= 1'b0;
      end else begin
         overrun <= done && res_valid && !res_ready;
         if (done) begin
            res_valid <= 1'b1;
            res_bin   <= max_bin;
            res_pow   <= max_pow;
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect: randomized frames against an argmax reference model.
module tb_fft_peak_detect;
   logic        clk, rst_n;
   logic        valid_in, sop_in, res_ready;
   logic [15:0] re_in, im_in;
   logic        res_valid, short_frame, overrun;
   logic [7:0]  res_bin;
   logic [32:0] res_pow;

   int errors = 0;
   int checks = 0;
   int sf_cnt = 0;
   int ov_cnt = 0;
   int fr_re[256];
   int fr_im[256];

`ifdef FFT_PEAK_SKIP_DC_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   fft_peak_detect dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sop_in(sop_in),
      .re_in(re_in), .im_in(im_in), .res_valid(res_valid), .res_ready(res_ready),
      .res_bin(res_bin), .res_pow(res_pow), .short_frame(short_frame), .overrun(overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (short_frame === 1'b1) sf_cnt++;
      if (overrun === 1'b1) ov_cnt++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic longint pw(input int b);
      return longint'(fr_re[b]) * fr_re[b] + longint'(fr_im[b]) * fr_im[b];
   endfunction

   // Strongest bin, lowest index on ties; with DC skipping the search starts at bin 1.
   function automatic void model(output int eb, output longint ep);
      int s;
      s  = SKIP ? 1 : 0;
      eb = s;
      ep = pw(s);
      for (int b = s + 1; b < 256; b++)
         if (pw(b) > ep) begin
            ep = pw(b);
            eb = b;
         end
   endfunction

   task automatic fill_small(input int mag);
      for (int i = 0; i < 256; i++) begin
         fr_re[i] = (mag == 0) ? 0 : int'($urandom_range(0, 2*mag)) - mag;
         fr_im[i] = (mag == 0) ? 0 : int'($urandom_range(0, 2*mag)) - mag;
      end
   endtask

   task automatic send_frame(input bit gaps, input int n);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            @(negedge clk);
            valid_in = 1'b0; sop_in = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         @(negedge clk);
         valid_in = 1'b1;
         sop_in   = (i == 0);
         re_in    = 16'(fr_re[i]);
         im_in    = 16'(fr_im[i]);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; valid_in = 1'b0; sop_in = 1'b0; re_in = '0; im_in = '0; res_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", res_valid); end
      checks++; if (res_bin !== 8'd0) begin errors++; $display("FAIL reset_bin got=%0d want=0", res_bin); end
      checks++; if (res_pow !== 33'd0) begin errors++; $display("FAIL reset_pow got=%0d want=0", res_pow); end
      checks++; if (short_frame !== 1'b0) begin errors++; $display("FAIL reset_short got=%b want=0", short_frame); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", overrun); end
      rst_n = 1'b1;
   endtask

   task automatic test_frame_patterns;
      int eb; longint ep;
      for (int sc = 0; sc < 7; sc++) begin
         case (sc)
            0: begin fill_small(0); fr_re[37] = 100; fr_im[37] = -200; end
            1: begin fill_small(0); fr_re[10] = 300; fr_im[10] = 400; fr_re[200] = 300; fr_im[200] = 400; end
            2: begin fill_small(50); fr_re[5] = -32768; fr_im[5] = -32768; end
            3: begin fill_small(0); fr_re[0] = 5000; fr_re[9] = 10; end
            4: fill_small(0);
            5: fill_small(32767);
            default: fill_small(200);
         endcase
         model(eb, ep);
         // Beats without sop while idle must be ignored.
         if (sc == 6)
            for (int g = 0; g < 10; g++) begin
               @(negedge clk);
               valid_in = 1'b1; sop_in = 1'b0; re_in = 16'h7fff; im_in = 16'h7fff;
            end
         send_frame(1'b0, 256);
         @(negedge clk); valid_in = 1'b0; sop_in = 1'b0;
         repeat (2) @(negedge clk);
         checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL pat%0d_early_valid got=%b want=0", sc, res_valid); end
         @(negedge clk);
         checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL pat%0d_valid got=%b want=1", sc, res_valid); end
         checks++; if (res_bin !== 8'(eb)) begin errors++; $display("FAIL pat%0d_bin got=%0d want=%0d", sc, res_bin, eb); end
         checks++; if (64'(res_pow) !== ep) begin errors++; $display("FAIL pat%0d_pow got=%0d want=%0d", sc, res_pow, ep); end
         @(negedge clk);
         checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL pat%0d_drop got=%b want=0", sc, res_valid); end
      end
   endtask

   task automatic test_gaps;
      int eb; longint ep;
      logic [7:0] first_bin;
      logic [32:0] first_pow;
      first_bin = '0; first_pow = '0;
      fill_small(30);
      fr_re[255] = 1000; fr_im[255] = 0;
      model(eb, ep);
      for (int run = 0; run < 2; run++) begin
         send_frame(run == 0, 256);
         @(negedge clk); valid_in = 1'b0; sop_in = 1'b0;
         repeat (2) @(negedge clk);
         checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL gaps%0d_early_valid got=%b want=0", run, res_valid); end
         @(negedge clk);
         checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL gaps%0d_valid got=%b want=1", run, res_valid); end
         checks++; if (res_bin !== 8'(eb)) begin errors++; $display("FAIL gaps%0d_bin got=%0d want=%0d", run, res_bin, eb); end
         checks++; if (64'(res_pow) !== ep) begin errors++; $display("FAIL gaps%0d_pow got=%0d want=%0d", run, res_pow, ep); end
         if (run == 0) begin
            first_bin = res_bin; first_pow = res_pow;
         end else begin
            checks++;
            if (res_bin !== first_bin || res_pow !== first_pow) begin
               errors++;
               $display("FAIL gaps_vs_nogap got=%0d/%0d want=%0d/%0d", res_bin, res_pow, first_bin, first_pow);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_short_frame;
      int eb; longint ep; int sf0;
      sf0 = sf_cnt;
      fill_small(10);
      fr_re[50] = 20000; fr_im[50] = 20000;
      send_frame(1'b0, 120);
      fill_small(10);
      fr_re[3] = 500; fr_im[3] = 500;
      model(eb, ep);
      send_frame(1'b0, 256);
      @(negedge clk); valid_in = 1'b0; sop_in = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL short_stray_valid got=%b want=0", res_valid); end
      @(negedge clk);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL short_valid got=%b want=1", res_valid); end
      checks++; if (res_bin !== 8'(eb)) begin errors++; $display("FAIL short_bin got=%0d want=%0d", res_bin, eb); end
      checks++; if (64'(res_pow) !== ep) begin errors++; $display("FAIL short_pow got=%0d want=%0d", res_pow, ep); end
      checks++; if (sf_cnt - sf0 !== 1) begin errors++; $display("FAIL short_pulses got=%0d want=1", sf_cnt - sf0); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int eb1, eb2; longint ep1, ep2; int ov0, sf0;
      ov0 = ov_cnt; sf0 = sf_cnt;
      res_ready = 1'b0;
      fill_small(40);
      fr_re[20] = 3000;
      model(eb1, ep1);
      send_frame(1'b0, 256);
      fill_small(40);
      fr_im[40] = 4000;
      model(eb2, ep2);
      send_frame(1'b0, 256);
      @(negedge clk); valid_in = 1'b0; sop_in = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got=%b want=1", res_valid); end
      checks++; if (res_bin !== 8'(eb1)) begin errors++; $display("FAIL hold_bin got=%0d want=%0d", res_bin, eb1); end
      checks++; if (64'(res_pow) !== ep1) begin errors++; $display("FAIL hold_pow got=%0d want=%0d", res_pow, ep1); end
      @(negedge clk);
      checks++; if (res_bin !== 8'(eb2)) begin errors++; $display("FAIL ovr_bin got=%0d want=%0d", res_bin, eb2); end
      checks++; if (64'(res_pow) !== ep2) begin errors++; $display("FAIL ovr_pow got=%0d want=%0d", res_pow, ep2); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse got=%b want=1", overrun); end
      @(negedge clk);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b want=0", overrun); end
      checks++; if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL ovr_count got=%0d want=1", ov_cnt - ov0); end
      checks++; if (sf_cnt - sf0 !== 0) begin errors++; $display("FAIL b2b_short got=%0d want=0", sf_cnt - sf0); end
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b want=1", res_valid); end
      res_ready = 1'b1;
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL ready_drop got=%b want=0", res_valid); end
   endtask

   task automatic test_reset_mid;
      int eb; longint ep;
      res_ready = 1'b0;
      fill_small(1000);
      send_frame(1'b0, 256);
      @(negedge clk); valid_in = 1'b0; sop_in = 1'b0;
      repeat (4) @(negedge clk);
      send_frame(1'b0, 100);
      @(negedge clk); rst_n = 1'b0; valid_in = 1'b0; sop_in = 1'b0;
      #1;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b want=0", res_valid); end
      checks++; if (res_bin !== 8'd0) begin errors++; $display("FAIL rstmid_bin got=%0d want=0", res_bin); end
      checks++; if (res_pow !== 33'd0) begin errors++; $display("FAIL rstmid_pow got=%0d want=0", res_pow); end
      @(negedge clk); rst_n = 1'b1; res_ready = 1'b1;
      fill_small(100);
      fr_re[77] = -700; fr_im[77] = 300;
      model(eb, ep);
      send_frame(1'b0, 256);
      @(negedge clk); valid_in = 1'b0; sop_in = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rstmid_after_valid got=%b want=1", res_valid); end
      checks++; if (res_bin !== 8'(eb)) begin errors++; $display("FAIL rstmid_after_bin got=%0d want=%0d", res_bin, eb); end
      checks++; if (64'(res_pow) !== ep) begin errors++; $display("FAIL rstmid_after_pow got=%0d want=%0d", res_pow, ep); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_frame_patterns();
      test_gaps();
      test_short_frame();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
